// File: rtl/board_clear_fsm.sv
// ============================================================================
// board_clear_fsm : removes full rows from a board snapshot, then spawns a piece
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module board_clear_fsm #(
  parameter int ROWS      = 8,
  parameter int COLS      = 4,
  parameter int SPAWN_COL = 1,
  parameter int SCORE_W   = 16,
  parameter int N         = ROWS * COLS,
  parameter int LC_W      = $clog2(ROWS + 1)
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       board_in,
  input  logic [1:0]         curr_piece,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       board_out,
  output logic               error,
  output logic [LC_W-1:0]    lines_cleared,
  output logic [SCORE_W-1:0] score
);

  localparam int PTR_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SPAWN = 2'd2
  } state_t;

  state_t              r_state;
  logic [N-1:0]        r_board;
  logic [1:0]          r_piece;
  logic [PTR_W-1:0]    r_ptr;
  logic [LC_W-1:0]     r_cnt;
  logic [N-1:0]        r_board_out;
  logic                r_error;
  logic [LC_W-1:0]     r_lc;
  logic [SCORE_W-1:0]  r_score;
  logic                r_done;

  state_t              w_state_nxt;
  logic [N-1:0]        w_board_nxt;
  logic [1:0]          w_piece_nxt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [LC_W-1:0]     w_cnt_nxt;
  logic [N-1:0]        w_out_nxt;
  logic                w_err_nxt;
  logic [LC_W-1:0]     w_lc_nxt;
  logic [SCORE_W-1:0]  w_score_nxt;
  logic                w_done_nxt;

  logic [ROWS-1:0]     w_row_full;
  logic                w_cur_full;
  logic [N-1:0]        w_shifted;
  logic [N-1:0]        w_mask;
  logic [SCORE_W:0]    w_score_sum;
  logic [SCORE_W-1:0]  w_score_sat;

  // Rows at or above the pointer drop by one; the top row refills with zeros.
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign w_row_full[gi] = &r_board[gi*COLS +: COLS];
      if (gi == 0) begin : g_top
        assign w_shifted[0 +: COLS] = '0;
      end else begin : g_rest
        assign w_shifted[gi*COLS +: COLS] = (PTR_W'(gi) <= r_ptr) ?
                                            r_board[(gi-1)*COLS +: COLS] :
                                            r_board[gi*COLS +: COLS];
      end
    end
  endgenerate

  assign w_cur_full = w_row_full[r_ptr];

  always_comb begin
    w_mask = '0;
    case (r_piece)
      2'b00: begin
        w_mask[SPAWN_COL] = 1'b1;
      end
      2'b01: begin
        w_mask[SPAWN_COL]     = 1'b1;
        w_mask[SPAWN_COL + 1] = 1'b1;
      end
      2'b10: begin
        w_mask[SPAWN_COL]            = 1'b1;
        w_mask[SPAWN_COL + 1]        = 1'b1;
        w_mask[COLS + SPAWN_COL]     = 1'b1;
        w_mask[COLS + SPAWN_COL + 1] = 1'b1;
      end
      default: begin
        w_mask[SPAWN_COL]            = 1'b1;
        w_mask[COLS + SPAWN_COL]     = 1'b1;
        w_mask[COLS + SPAWN_COL + 1] = 1'b1;
      end
    endcase
  end

  assign w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(r_cnt);
  assign w_score_sat = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_board_nxt = r_board;
    w_piece_nxt = r_piece;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_board_out;
    w_err_nxt   = r_error;
    w_lc_nxt    = r_lc;
    w_score_nxt = r_score;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_board_nxt = board_in;
          w_piece_nxt = curr_piece;
          w_ptr_nxt   = PTR_W'(ROWS - 1);
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // A cleared row keeps the pointer so the row that fell into it is re-checked.
        if (w_cur_full) begin
          w_board_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + LC_W'(1);
        end else if (r_ptr != '0) begin
          w_ptr_nxt   = r_ptr - PTR_W'(1);
        end else begin
          w_state_nxt = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        w_out_nxt   = r_board | w_mask;
        w_err_nxt   = |(r_board & w_mask);
        w_lc_nxt    = r_cnt;
        w_score_nxt = w_score_sat;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_board     <= '0;
      r_piece     <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_board_out <= '0;
      r_error     <= 1'b0;
      r_lc        <= '0;
      r_score     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_board     <= w_board_nxt;
      r_piece     <= w_piece_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_board_out <= w_out_nxt;
      r_error     <= w_err_nxt;
      r_lc        <= w_lc_nxt;
      r_score     <= w_score_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign board_out     = r_board_out;
  assign error         = r_error;
  assign lines_cleared = r_lc;
  assign score         = r_score;

endmodule

`default_nettype wire

// File: tb/tb_board_clear_fsm.sv
// ============================================================================
// tb_board_clear_fsm : directed bench for board_clear_fsm (8x4 board, spawn column 1)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_clear_fsm;

  logic        clka;
  logic        reset;
  logic        start;
  logic [31:0] board_in;
  logic [1:0]  curr_piece;
  logic        busy;
  logic        done;
  logic [31:0] board_out;
  logic        error;
  logic [3:0]  lines_cleared;
  logic [15:0] score;

  int n_chk  = 0;
  int n_pass = 0;
  int model_score = 0;

  board_clear_fsm #(
    .ROWS      (8),
    .COLS      (4),
    .SPAWN_COL (1),
    .SCORE_W   (16)
  ) dut (
    .clka          (clka),
    .reset         (reset),
    .start         (start),
    .board_in      (board_in),
    .curr_piece    (curr_piece),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .error         (error),
    .lines_cleared (lines_cleared),
    .score         (score)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_board_out"}, 64'(board_out), 64'(0));
    check_val({tag, "_error"}, 64'(error), 64'(0));
    check_val({tag, "_lines"}, 64'(lines_cleared), 64'(0));
    check_val({tag, "_score"}, 64'(score), 64'(0));
    check_val({tag, "_busy"}, 64'(busy), 64'(0));
    check_val({tag, "_done"}, 64'(done), 64'(0));
  endtask

  // Launches one operation from the current (mid-cycle) point and returns #1 after the done edge.
  task automatic run_op(input string tag, input logic [31:0] brd, input logic [1:0] pc,
                        input logic [31:0] exp_out, input logic exp_err, input int exp_lc,
                        input int exp_edge, input bit poke_busy);
    int done_edge;
    done_edge  = 0;
    board_in   = brd;
    curr_piece = pc;
    start      = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    check_val({tag, "_busy_after_start"}, 64'(busy), 64'(1));
    for (int e = 1; e <= 40; e++) begin
      if (poke_busy && e == 3) begin
        start      = 1'b1;
        board_in   = 32'h0;
        curr_piece = 2'b10;
      end
      @(posedge clka); #1;
      start = 1'b0;
      if (done) begin
        done_edge = e;
        break;
      end
    end
    model_score = model_score + exp_lc;
    if (model_score > 65535) model_score = 65535;
    check_val({tag, "_done_edge"}, 64'(done_edge), 64'(exp_edge));
    check_val({tag, "_board_out"}, 64'(board_out), 64'(exp_out));
    check_val({tag, "_error"}, 64'(error), 64'(exp_err));
    check_val({tag, "_lines"}, 64'(lines_cleared), 64'(exp_lc));
    check_val({tag, "_score"}, 64'(score), 64'(model_score));
    check_val({tag, "_busy_in_done"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int n_done;
    reset      = 1'b1;
    start      = 1'b0;
    board_in   = 32'h0;
    curr_piece = 2'b00;

    @(posedge clka); #1;
    check_all_zero("por");
    reset = 1'b0;
    @(posedge clka); #1;

    run_op("empty_p10", 32'h0000_0000, 2'b10, 32'h0000_0066, 1'b0, 0, 9, 1'b0);
    // Started in the done cycle of the previous operation.
    run_op("two_rows", 32'hFF30_0000, 2'b00, 32'h3000_0002, 1'b0, 2, 11, 1'b0);

    repeat (3) @(posedge clka);
    #1;
    check_val("hold_board_out", 64'(board_out), 64'(32'h3000_0002));
    check_val("hold_error", 64'(error), 64'(0));
    check_val("hold_lines", 64'(lines_cleared), 64'(2));
    check_val("hold_done", 64'(done), 64'(0));

    run_op("nonadj", 32'hF1F0_0000, 2'b01, 32'h1000_0006, 1'b0, 2, 11, 1'b0);
    run_op("collide", 32'h0000_0002, 2'b11, 32'h0000_0062, 1'b1, 0, 9, 1'b0);
    run_op("all_full", 32'hFFFF_FFFF, 2'b00, 32'h0000_0002, 1'b0, 8, 17, 1'b1);

    #2 reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_score = 0;
    @(posedge clka); #1;
    reset = 1'b0;

    // Abort a repeat of the all-full run at edge 5.
    board_in   = 32'hFFFF_FFFF;
    curr_piece = 2'b00;
    start      = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    repeat (5) @(posedge clka);
    #1 reset = 1'b1;
    #1;
    check_val("abort_busy", 64'(busy), 64'(0));
    check_val("abort_score", 64'(score), 64'(0));
    repeat (2) @(posedge clka);
    #1 reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clka); #1;
      if (done) n_done++;
    end
    check_val("abort_no_done", 64'(n_done), 64'(0));
    check_val("abort_score_after", 64'(score), 64'(0));
    check_val("abort_idle", 64'(busy), 64'(0));

    run_op("fresh", 32'h0000_0000, 2'b10, 32'h0000_0066, 1'b0, 0, 9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/board_clear_fsm.md
BOARD_CLEAR_FSM -- requirements
Module: board_clear_fsm

Interface
REQ-001 Parameter ROWS, default 8: number of board rows (2..32).
REQ-002 Parameter COLS, default 4: cells per row (3..16).
REQ-003 Parameter SPAWN_COL, default 1: leftmost spawn column; SPAWN_COL+1 <= COLS-1.
REQ-004 Parameter SCORE_W, default 16: width of the score counter.
REQ-005 Derived parameters: N = ROWS*COLS; LC_W = clog2(ROWS+1).
REQ-006 clka  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  request to clear the board and spawn a piece; sampled only in IDLE.
REQ-009 board_in  in  N  board snapshot; cell (r,c) is bit r*COLS+c; row 0 is the top row, row ROWS-1 is the bottom row.
REQ-010 curr_piece  in  2  piece to spawn; sampled together with board_in.
REQ-011 busy  out  1  high while in the SCAN or SPAWN state.
REQ-012 done  out  1  one-cycle pulse: result outputs are updated.
REQ-013 board_out  out  N  cleared board with the spawned piece.
REQ-014 error  out  1  spawn collision flag for the last operation.
REQ-015 lines_cleared  out  LC_W  number of rows cleared in the last operation.
REQ-016 score  out  SCORE_W  running total of cleared rows.

Function
REQ-017 The FSM SHALL have states IDLE, SCAN and SPAWN.
REQ-018 IDLE with start=1: latch board_in into the working board and curr_piece into a piece register, set ptr=ROWS-1 and cnt=0, then go to SCAN.
REQ-019 IDLE with start=0: hold state; all outputs hold.
REQ-020 SCAN, row[ptr] all ones: row[i]=row[i-1] for i=ptr..1, row[0]=0, cnt+1, ptr unchanged (the same row is re-checked next cycle).
REQ-021 SCAN, row[ptr] not full and ptr>0: ptr-1.
REQ-022 SCAN, row[ptr] not full and ptr=0: go to SPAWN.
REQ-023 The SCAN stage SHALL take exactly ROWS+k cycles, where k is the number of rows cleared.
REQ-024 Piece masks, with S=SPAWN_COL: 00 = (0,S); 01 = (0,S),(0,S+1); 10 = (0,S),(0,S+1),(1,S),(1,S+1); 11 = (0,S),(1,S),(1,S+1).
REQ-025 SPAWN (1 cycle): error = OR of (mask AND working board); board_out = working board OR mask, regardless of error.
REQ-026 SPAWN SHALL also set lines_cleared=cnt, add cnt to score (saturating at all ones), pulse done=1 on the next cycle, and return to IDLE.
REQ-027 Latency: with the start-capture edge as edge 0, done SHALL be high after edge ROWS+k+1; busy SHALL be low in the done cycle.
REQ-028 start while busy SHALL be ignored; start in the done cycle SHALL be accepted.
REQ-029 Non-adjacent and multiple full rows SHALL all be cleared in one operation; an all-full board yields k=ROWS.
REQ-030 board_out, error and lines_cleared SHALL hold between done pulses.

Reset
REQ-031 Reset SHALL force the state to IDLE and clear board_out, error, lines_cleared, score, busy, done, ptr and cnt to 0, immediately and without a clock.
REQ-032 Reset mid-operation SHALL abort with no done pulse; the first start after release begins a fresh operation.

Verification (ROWS=8, COLS=4, SPAWN_COL=1)
REQ-033 Assert reset asynchronously -> all outputs 0 before the next clka edge.
REQ-034 board_in=0x00000000, piece=10 -> board_out=0x00000066, error=0, lines_cleared=0, done after edge 9.
REQ-035 board_in=0xFF300000, piece=00 -> board_out=0x30000002, lines_cleared=2, score +2, done after edge 11.
REQ-036 board_in=0xF1F00000, piece=01 -> board_out=0x10000006, lines_cleared=2 (non-adjacent rows cleared).
REQ-037 board_in=0x00000002, piece=11 -> error=1, board_out=0x00000062, lines_cleared=0.
REQ-038 board_in=0xFFFFFFFF, piece=00 -> board_out=0x00000002, lines_cleared=8, done after edge 17; start pulsed while busy is ignored; reset asserted at edge 5 of a repeat run -> no done pulse, score=0.
